// File: rtl/data_mem_ctrl_pkg.sv
// data_mem_ctrl_pkg: shared FSM states, access-size encodings and LED address default.
package data_mem_ctrl_pkg;
   typedef enum logic [2:0] {IDLE, RD_WAIT, RMW_WR, WR, RESP} state_t;
   localparam logic [1:0]  SZ_B = 2'b00;
   localparam logic [1:0]  SZ_H = 2'b01;
   localparam logic [1:0]  SZ_W = 2'b10;
   localparam logic [31:0] LED_ADDR_DEF = 32'hFFFF_FF00;
   // funct3 011/110/111 collapse to word size
   function automatic logic [1:0] size_of(input logic [2:0] f3);
      return (f3[1:0] == 2'b11) ? SZ_W : f3[1:0];
   endfunction
endpackage

// File: rtl/data_mem_ctrl_lane_unit.sv
// mem_lane_unit: combinational load extract/extend and sub-word store merge.
module mem_lane_unit
   import data_mem_ctrl_pkg::*;
(
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   input  logic [2:0]  funct3,
   input  logic [1:0]  lane,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);
   logic [1:0]  sz;
   logic [31:0] sh_b, sh_h, mask_b, mask_h;
   logic        sx;
   always_comb begin
      sz = size_of(funct3);
      sx = ~funct3[2];
      sh_b = word >> {lane, 3'b000};
      sh_h = word >> {lane[1], 4'b0000};
      mask_b = 32'h0000_00FF << {lane, 3'b000};
      mask_h = 32'h0000_FFFF << {lane[1], 4'b0000};
      load_data = (sz == SZ_B) ? {{24{sx & sh_b[7]}}, sh_b[7:0]} :
                  (sz == SZ_H) ? {{16{sx & sh_h[15]}}, sh_h[15:0]} : word;
      store_word = (sz == SZ_B) ? ((word & ~mask_b) | (({24'b0, wdata[7:0]} << {lane, 3'b000}) & mask_b)) :
                   (sz == SZ_H) ? ((word & ~mask_h) | (({16'b0, wdata[15:0]} << {lane[1], 4'b0000}) & mask_h)) :
                   wdata;
   end
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: RV32 load/store controller with RMW sub-word stores and an LED register.
// Optional MEM_MISALIGN_TRAP_EN: misaligned half/word accesses respond immediately with misalign_err.
module data_mem_ctrl
   import data_mem_ctrl_pkg::*;
#(
   parameter int          RAM_LATENCY = 1,
   parameter logic [31:0] LED_ADDR    = LED_ADDR_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   output logic        ram_we,
   input  logic [31:0] ram_rdata,
   output logic [5:0]  led
`ifdef MEM_MISALIGN_TRAP_EN
   ,output logic       misalign_err
`endif
);
   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, resp_rdata_q, resp_rdata_d;
   logic [2:0]  funct3_q, funct3_d;
   logic        write_q, write_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [5:0]  led_q, led_d;
   logic [31:0] lane_word, load_data, store_word;
   logic [1:0]  sz;
   logic        is_led, mis;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        mis_q, mis_d;
   assign misalign_err = mis_q & resp_valid;
`endif

   // during RD_WAIT extract straight from RAM; later phases merge into the captured word
   assign lane_word = (state_q == RD_WAIT) ? ram_rdata : rdata_q;

   mem_lane_unit u_lane (
      .word       (lane_word),
      .wdata      (wdata_q),
      .funct3     (funct3_q),
      .lane       (addr_q[1:0]),
      .load_data  (load_data),
      .store_word (store_word)
   );

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_rdata = resp_rdata_q;
   assign ram_we     = (state_q == WR) || (state_q == RMW_WR);
   assign ram_wdata  = ram_we ? store_word : 32'h0;
   assign ram_addr   = (ram_we || state_q == RD_WAIT) ? {addr_q[31:2], 2'b00} : 32'h0;
   assign led        = led_q;

   always_comb begin
      state_d = state_q;
      addr_d = addr_q;
      wdata_d = wdata_q;
      funct3_d = funct3_q;
      write_d = write_q;
      cnt_d = cnt_q;
      rdata_d = rdata_q;
      led_d = led_q;
      resp_rdata_d = resp_rdata_q;
      sz = size_of(req_funct3);
      is_led = (req_addr[31:2] == LED_ADDR[31:2]);
`ifdef MEM_MISALIGN_TRAP_EN
      mis = ((sz == SZ_H) & req_addr[0]) | ((sz == SZ_W) & (|req_addr[1:0]));
      mis_d = mis_q;
`else
      mis = 1'b0;
`endif
      case (state_q)
         IDLE: if (req_valid) begin
            addr_d = req_addr;
            wdata_d = req_wdata;
            funct3_d = req_funct3;
            write_d = req_write;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_d = mis;
`endif
            if (mis) begin
               state_d = RESP;
               resp_rdata_d = 32'h0;
            end else if (is_led) begin
               state_d = RESP;
               led_d = req_write ? req_wdata[5:0] : led_q;
               resp_rdata_d = req_write ? 32'h0 : {26'b0, led_q};
            end else if (req_write && sz == SZ_W) begin
               state_d = WR;
            end else begin
               state_d = RD_WAIT;
               cnt_d = RAM_LATENCY[7:0];
            end
         end
         RD_WAIT: begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
               rdata_d = ram_rdata;
               state_d = write_q ? RMW_WR : RESP;
               resp_rdata_d = write_q ? 32'h0 : load_data;
            end
         end
         RMW_WR, WR: begin
            state_d = RESP;
            resp_rdata_d = 32'h0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q <= 32'h0;
         wdata_q <= 32'h0;
         funct3_q <= 3'b0;
         write_q <= 1'b0;
         cnt_q <= 8'd0;
         rdata_q <= 32'h0;
         led_q <= 6'h0;
         resp_rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
         funct3_q <= funct3_d;
         write_q <= write_d;
         cnt_q <= cnt_d;
         rdata_q <= rdata_d;
         led_q <= led_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) mis_q <= 1'b0;
      else mis_q <= mis_d;
   end
`endif
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: scoreboard bench for data_mem_ctrl with a behavioural word RAM (latency 1).
module tb_data_mem_ctrl;
   localparam logic [31:0] LED = 32'hFFFF_FF00;
   logic        clk = 1'b0, rst = 1'b1;
   logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
   logic [2:0]  req_funct3 = 3'b0;
   logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
   logic        resp_valid, ram_we;
   logic [31:0] resp_rdata, ram_addr, ram_wdata, ram_rdata;
   logic [5:0]  led;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        misalign_err;
`endif
   logic [31:0] mem [0:255];
   logic [31:0] exp_q [$];
   int          n_chk = 0, n_err = 0, we_cnt = 0;

   data_mem_ctrl dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
      .ram_rdata(ram_rdata), .led(led)
`ifdef MEM_MISALIGN_TRAP_EN
      , .misalign_err(misalign_err)
`endif
   );

   always #5 clk = ~clk;

   assign ram_rdata = mem[ram_addr[9:2]];
   always @(posedge clk) begin
      if (ram_we) begin
         mem[ram_addr[9:2]] <= ram_wdata;
         we_cnt <= we_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (resp_valid) begin
         if (exp_q.size() == 0) check("spurious_resp", 32'h1, 32'h0);
         else check("rdata", resp_rdata, exp_q.pop_front());
      end
   end

   task automatic op(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input int exp_lat, input int exp_we);
      int lat, wait_c, we0;
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
      wait_c = 0;
      while (!req_ready && wait_c < 20) begin
         @(negedge clk);
         wait_c++;
      end
      check("ready", 32'(req_ready), 32'h1);
      exp_q.push_back(exp_rd);
      we0 = we_cnt;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 20) begin
         @(posedge clk);
         #1 lat++;
      end
      check("latency", 32'(lat), 32'(exp_lat));
      check("we_pulses", 32'(we_cnt - we0), 32'(exp_we));
   endtask

   initial begin
      int we0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      #1 check("rst_ready", 32'(req_ready), 32'h1);
      check("rst_resp_valid", 32'(resp_valid), 32'h0);
      check("rst_ram_we", 32'(ram_we), 32'h0);
      check("rst_ram_addr", ram_addr, 32'h0);
      check("rst_led", 32'(led), 32'h0);
      check("rst_rdata", resp_rdata, 32'h0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 2, 1);
      check("mem_sw", mem[4], 32'hDEADBEEF);
      op(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 2, 0);
      mem[8] = 32'h11223344;
      op(1'b1, 3'b000, 32'h21, 32'hAA, 32'h0, 3, 1);
      check("mem_sb", mem[8], 32'h1122AA44);
      op(1'b0, 3'b000, 32'h21, 32'h0, 32'hFFFFFFAA, 2, 0);
      op(1'b0, 3'b100, 32'h21, 32'h0, 32'h000000AA, 2, 0);
      mem[8] = 32'h0;
      op(1'b1, 3'b001, 32'h22, 32'h8001, 32'h0, 3, 1);
      check("mem_sh", mem[8], 32'h80010000);
      op(1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF8001, 2, 0);
      op(1'b0, 3'b101, 32'h22, 32'h0, 32'h00008001, 2, 0);
      // reset while a sub-word store waits on RAM: the RMW write must never appear
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000; req_addr = 32'h11; req_wdata = 32'h77;
      @(posedge clk);
      #1 req_valid = 1'b0;
      we0 = we_cnt;
      rst = 1'b1;
      #1 check("mid_rst_we", 32'(ram_we), 32'h0);
      check("mid_rst_ready", 32'(req_ready), 32'h1);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_rst_no_write", 32'(we_cnt - we0), 32'h0);
      check("mid_rst_led", 32'(led), 32'h0);
      check("mid_rst_mem", mem[4], 32'hDEADBEEF);
      op(1'b1, 3'b010, LED, 32'h3F, 32'h0, 1, 0);
      check("led_val", 32'(led), 32'h3F);
      op(1'b0, 3'b010, LED, 32'h0, 32'h3F, 1, 0);
      op(1'b1, 3'b000, LED + 32'h1, 32'h15, 32'h0, 1, 0);
      check("led_sb", 32'(led), 32'h15);
`ifdef MEM_MISALIGN_TRAP_EN
      op(1'b0, 3'b010, 32'h13, 32'h0, 32'h0, 1, 0);
`else
      op(1'b0, 3'b010, 32'h13, 32'h0, 32'hDEADBEEF, 2, 0);
      op(1'b0, 3'b001, 32'h23, 32'h0, 32'hFFFF8001, 2, 0);
`endif
      op(1'b1, 3'b000, 32'h10, 32'hFFFFFF5A, 32'h0, 3, 1);
      check("mem_sb_lane0", mem[4], 32'hDEADBE5A);
      op(1'b0, 3'b110, 32'h10, 32'h0, 32'hDEADBE5A, 2, 0);
      op(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 2, 0);
      repeat (2) @(negedge clk);
      check("sb_empty", 32'(exp_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1);
   end
endmodule
